wb_uart_master: RTL and testbench



---
 rtl/wb_uart_master.sv | 174 +++++++++++++++++
 tb/tb_wb_uart_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_master.sv
// Wishbone master driven by a UART byte stream: READ/WRITE command frames in, status or read-data bytes out.
// Each bus cycle starts one edge after the last frame byte. Responses are paced by tx_busy. No rx buffering.
module wb_uart_master #(
    parameter int timeout = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int WD_W = (timeout < 1) ? 1 : $clog2(timeout + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(timeout);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     rdat_q, rdat_d;
    logic            we_q, we_d;
    logic            cyc_q, cyc_d;
    logic            err_q, err_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_wr_q, tx_wr_d;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdat_d    = rdat_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        err_d     = err_q;
        wdog_d    = wdog_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        // The transmitter raises tx_busy a cycle late, so stay off it for the pulse cycle and the one after.
        hold_d    = tx_wr_q;

        case (state_q)
            S_IDLE: begin
                if (rx_avail && (rx_data == 8'h01 || rx_data == 8'h02)) begin
                    we_d    = (rx_data == 8'h02);
                    cnt_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_avail) begin
                    adr_d = {adr_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_BUS;
                            cyc_d   = 1'b1;
                            wdog_d  = '0;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rx_avail) begin
                    dat_d = {dat_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        wdog_d  = '0;
                    end
                end
            end
            S_BUS: begin
                if (wb_err_i || (!wb_ack_i && wdog_q == WD_MAX)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b0;
                    if (!we_q) rdat_d = wb_dat_i;
                    state_d = S_RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_RESP: begin
                if (!tx_wr_q && !hold_q && !tx_busy) begin
                    tx_wr_d = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (err_q) begin
                        tx_data_d = 8'h45;
                    end else if (we_q) begin
                        tx_data_d = 8'h2A;
                    end else begin
                        tx_data_d = rdat_q[31:24];
                        rdat_d    = {rdat_q[23:0], 8'h00};
                    end
                    if (err_q || we_q || cnt_q == 2'd3) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            rdat_q    <= 32'h0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            err_q     <= 1'b0;
            wdog_q    <= '0;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdat_q    <= rdat_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign tx_data  = tx_data_q;
    assign tx_wr    = tx_wr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wb_uart_master.sv
// Scoreboard bench for wb_uart_master: stimulus pushes expected bus cycles and tx bytes,
// independent monitors pop and compare them as the DUT produces them.
module tb_wb_uart_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy;

    always #5 clk = ~clk;

    wb_uart_master #(.timeout(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        int          len;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [7:0]  tx_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    int          tx_busy_len = 0;
    int          busy_left   = 0;
    int          ack_after   = 0;
    bit          err_mode    = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    int          scyc        = 0;

    int          cyc_len = 0;
    logic [31:0] cap_adr, cap_dat;
    logic        cap_we;
    bit          unstable;
    bus_exp_t    be;
    logic [7:0]  tx_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Slave: acks (and optionally errs) on the ack_after-th cycle of cyc; ack_after=0 means silent.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_cyc_o && wb_stb_o) begin
                scyc++;
                wb_ack_i = (ack_after != 0 && scyc == ack_after);
                wb_err_i = err_mode && wb_ack_i;
                wb_dat_i = slave_rdata;
            end else begin
                scyc     = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end
    end

    // Transmitter model and tx scoreboard.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_wr) begin
                check("tx_wr_while_busy", 32'(tx_busy), 32'h0);
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h, expected no byte", tx_data);
                end else begin
                    tx_exp = tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(tx_exp));
                end
                busy_left = tx_busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            tx_busy = (busy_left > 0);
        end
    end

    // Bus scoreboard: one entry per cyc pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_cyc_o) begin
                if (cyc_len == 0) begin
                    cap_adr  = wb_adr_o;
                    cap_dat  = wb_dat_o;
                    cap_we   = wb_we_o;
                    unstable = 1'b0;
                end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat || wb_we_o !== cap_we) begin
                    unstable = 1'b1;
                end
                if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) unstable = 1'b1;
                cyc_len++;
            end else if (cyc_len != 0) begin
                if (bus_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_unexpected: got cycle adr %h, expected no cycle", cap_adr);
                end else begin
                    be = bus_q.pop_front();
                    check("bus_adr", cap_adr, be.adr);
                    check("bus_we", 32'(cap_we), 32'(be.we));
                    if (be.we) check("bus_dat", cap_dat, be.dat);
                    check("bus_len", 32'(cyc_len), 32'(be.len));
                    check("bus_stable", 32'(unstable), 32'h0);
                end
                cyc_len = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_avail = 1'b1;
        @(negedge clk);
        rx_avail = 1'b0;
    endtask

    task automatic send_read(input logic [31:0] adr);
        send_byte(8'h01);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
    endtask

    task automatic send_write(input logic [31:0] adr, input logic [31:0] dat);
        send_byte(8'h02);
        for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
    endtask

    task automatic expect_bus(input logic [31:0] adr, input logic [31:0] dat, input logic we, input int len);
        bus_exp_t e;
        e.adr = adr;
        e.dat = dat;
        e.we  = we;
        e.len = len;
        bus_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'h0);
        check({name, "_txq_left"}, 32'(tx_q.size()), 32'h0);
        check({name, "_busq_left"}, 32'(bus_q.size()), 32'h0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_cyc"}, 32'(wb_cyc_o), 32'h0);
        check({name, "_stb"}, 32'(wb_stb_o), 32'h0);
        check({name, "_we"}, 32'(wb_we_o), 32'h0);
        check({name, "_tx_wr"}, 32'(tx_wr), 32'h0);
        check({name, "_busy"}, 32'(busy), 32'h0);
        check({name, "_adr"}, wb_adr_o, 32'h0);
        check({name, "_dat"}, wb_dat_o, 32'h0);
        check({name, "_tx_data"}, 32'(tx_data), 32'h0);
        check({name, "_sel"}, 32'(wb_sel_o), 32'hF);
    endtask

    initial begin
        reset    = 1'b1;
        rx_avail = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // Write, 1-cycle ack slave.
        ack_after = 2; tx_busy_len = 0;
        expect_bus(32'h0000_7002, 32'hDEAD_BEEF, 1'b1, 2);
        tx_q.push_back(8'h2A);
        send_write(32'h0000_7002, 32'hDEAD_BEEF);
        wait_idle("write");

        // Read, 3 wait states, slow transmitter.
        ack_after = 4; tx_busy_len = 20; slave_rdata = 32'h1234_5678;
        expect_bus(32'h4000_0010, 32'h0, 1'b0, 4);
        tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
        send_read(32'h4000_0010);
        wait_idle("read");

        // Silent slave: watchdog abort after timeout+1 cycles.
        ack_after = 0; tx_busy_len = 2;
        expect_bus(32'h0000_0100, 32'h0, 1'b0, 17);
        tx_q.push_back(8'h45);
        send_read(32'h0000_0100);
        wait_idle("timeout");

        // err together with ack: err wins.
        ack_after = 2; err_mode = 1'b1;
        expect_bus(32'h0000_0020, 32'h1122_3344, 1'b1, 2);
        tx_q.push_back(8'h45);
        send_write(32'h0000_0020, 32'h1122_3344);
        wait_idle("err_ack");
        err_mode = 1'b0;

        // Garbage command byte, then a normal read.
        send_byte(8'h55);
        check("garbage_busy_now", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        check("garbage_busy_later", 32'(busy), 32'h0);
        slave_rdata = 32'hCAFE_F00D;
        expect_bus(32'h0000_0204, 32'h0, 1'b0, 2);
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
        send_read(32'h0000_0204);
        wait_idle("garbage_read");

        // Overrun: command-looking bytes during BUS and RESP must be dropped.
        ack_after = 4; tx_busy_len = 20; slave_rdata = 32'h0BAD_C0DE;
        expect_bus(32'h0000_0300, 32'h0, 1'b0, 4);
        tx_q.push_back(8'h0B); tx_q.push_back(8'hAD); tx_q.push_back(8'hC0); tx_q.push_back(8'hDE);
        send_read(32'h0000_0300);
        send_byte(8'h02);
        send_byte(8'h01);
        for (int i = 0; i < 100; i++) begin
            if (!wb_cyc_o) break;
            @(negedge clk);
        end
        check("overrun_cyc_end", 32'(wb_cyc_o), 32'h0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h01);
        wait_idle("overrun");
        ack_after = 2; tx_busy_len = 0;
        expect_bus(32'h0000_0404, 32'h55AA_55AA, 1'b1, 2);
        tx_q.push_back(8'h2A);
        send_write(32'h0000_0404, 32'h55AA_55AA);
        wait_idle("after_overrun");

        // Reset after the second address byte.
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h5A);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_frame");
        reset = 1'b0;

        // Reset while a write stalls on a silent slave.
        ack_after = 0;
        expect_bus(32'h0000_0500, 32'hFEED_FACE, 1'b1, 5);
        send_write(32'h0000_0500, 32'hFEED_FACE);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_bus");
        reset = 1'b0;

        // Fresh write after the resets.
        ack_after = 2;
        expect_bus(32'h0000_0600, 32'h0F0F_0F0F, 1'b1, 2);
        tx_q.push_back(8'h2A);
        send_write(32'h0000_0600, 32'h0F0F_0F0F);
        wait_idle("post_reset");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
